pixel_stream_packer: RTL and testbench
======================================

Name: pixel_stream_packer

Overview:
- Downstream stage of the ray tracing unit: consumes the per-pixel valid/red/green/blue output and emits a 24-bit video stream with ready/valid handshake, start-of-frame and end-of-line markers.
- The ray tracing unit has no stall input, so this block absorbs output backpressure in an internal FIFO and flags any dropped pixel.
- Output x/y counters frame the stream using the image width and height.

Parameters:
- FIFO_DEPTH, 16, FIFO entries (power of two, >=2).
- COLOR_W, 8, bits per colour channel; tdata width is 3*COLOR_W.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  1  pixel present on red/green/blue this cycle (driven from the ray tracing unit's validRead).
- red  in  COLOR_W  red channel.
- green  in  COLOR_W  green channel.
- blue  in  COLOR_W  blue channel.
- image_width  in  13  pixels per line; 0 is treated as 1.
- image_height  in  13  lines per frame; 0 is treated as 1.
- out_tdata  out  3*COLOR_W  {red, green, blue}, red in the MSBs.
- out_tvalid  out  1  out_tdata is valid.
- out_tready  in  1  sink accepts; a transfer occurs when out_tvalid && out_tready.
- out_tuser  out  1  high on the first pixel of a frame (x==0, y==0).
- out_tlast  out  1  high on the last pixel of each line (x==width-1).
- frame_done  out  1  one-cycle pulse in the cycle after the last pixel of a frame transfers.
- overflow  out  1  sticky; set when a pixel is dropped, cleared only by reset.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, any time including mid-frame): FIFO emptied; x=0, y=0; state IDLE; out_tvalid=0, out_tdata=0, out_tuser=0, out_tlast=0, frame_done=0, overflow=0, fifo_level=0. A partial frame is discarded and the next pixel starts a new frame with tuser=1.
- FIFO write: on valid_in, when not full, or when full and a transfer happens in the same cycle.
- Full with no same-cycle transfer: the pixel is dropped, overflow is set the next cycle, and x/y are not advanced for the dropped pixel.
- FIFO read: on each transfer.
- Latency: a pixel written into an empty FIFO in cycle N appears with out_tvalid=1 in cycle N+1.
- Simultaneous write and read keep fifo_level unchanged.
- out_tdata, out_tuser and out_tlast must stay stable while out_tvalid && !out_tready.
- Geometry: effective width W = max(image_width,1); effective height H = max(image_height,1).
- In IDLE, W and H are re-latched every cycle. In ACTIVE they are frozen.
- State machine:
  - IDLE -> ACTIVE on the first transfer of a frame.
  - ACTIVE -> IDLE on the transfer with x==W-1 and y==H-1.
  - A single-pixel frame (W=H=1) goes IDLE -> IDLE, with frame_done still pulsed.
- Counters advance only on a transfer:
  - x increments; at x==W-1, x wraps to 0 and y increments.
  - At y==H-1 with x==W-1, both wrap to 0.
- out_tuser = (x==0 && y==0) and out_tlast = (x==W-1), both taken from the counters describing the head pixel.
- frame_done: registered, high exactly one cycle after the final transfer.
- Input changes to image_width/height during ACTIVE take effect only on the next frame.

Test Plan:
- W=4, H=2, out_tready=1, 8 consecutive valid_in with red=0..7 -> 8 transfers, each with tdata={i,0,0} and 1-cycle latency; tuser only on pixel 0; tlast on pixels 3 and 7; frame_done pulses once, the cycle after pixel 7; overflow=0.
- FIFO_DEPTH=16, out_tready=0, 17 valid_in -> fifo_level=16, the 17th pixel is dropped, overflow=1; then out_tready=1 -> exactly the first 16 pixels emerge in order.
- FIFO full while out_tready=1 and valid_in on the same cycle -> the pixel is accepted, level stays 16, overflow stays 0.
- out_tready toggling 1/0 every cycle, W=3, H=3 -> tdata, tuser and tlast held stable during stalls; 9 pixels in order; tlast on pixels 2, 5, 8.
- reset asserted after 5 pixels of a W=4, H=2 frame, then 8 new pixels -> the first post-reset pixel carries tuser=1 and a full frame with correct tlast positions follows.
- image_width=0, image_height=0 -> every pixel has tuser=1 and tlast=1, and frame_done pulses after each pixel; changing image_width to 2 mid-frame with W=4 does not alter the current frame's tlast positions.

Source files
------------

// File: rtl/pixel_stream_packer.sv
// pixel_stream_packer: buffers ray tracer pixels into a framed 24-bit ready/valid video stream
module pixel_stream_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int COLOR_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  input  logic [COLOR_W-1:0]            red,
  input  logic [COLOR_W-1:0]            green,
  input  logic [COLOR_W-1:0]            blue,
  input  logic [12:0]                   image_width,
  input  logic [12:0]                   image_height,
  output logic [3*COLOR_W-1:0]          out_tdata,
  output logic                          out_tvalid,
  input  logic                          out_tready,
  output logic                          out_tuser,
  output logic                          out_tlast,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_n;
  logic [3*COLOR_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [12:0] x, y, w, h;
  logic full, xfer, wr, last_x, last_pix;
  assign full = fifo_level == (AW+1)'(FIFO_DEPTH);
  assign out_tvalid = fifo_level != '0;
  assign out_tdata = out_tvalid ? mem[rptr] : '0;
  assign xfer = out_tvalid && out_tready;
  assign wr = valid_in && (!full || xfer);
  assign last_x = x == w - 13'd1;
  assign last_pix = last_x && y == h - 13'd1;
  assign out_tuser = out_tvalid && x == '0 && y == '0;
  assign out_tlast = out_tvalid && last_x;
  always_comb begin
    state_n = state;
    if (xfer) state_n = last_pix ? IDLE : ACTIVE;
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= {red, green, blue};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wptr <= '0;
      rptr <= '0;
      fifo_level <= '0;
      x <= '0;
      y <= '0;
      w <= 13'd1;
      h <= 13'd1;
      frame_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      if (wr) wptr <= wptr + 1'b1;
      if (xfer) rptr <= rptr + 1'b1;
      fifo_level <= fifo_level + (AW+1)'(wr) - (AW+1)'(xfer);
      frame_done <= xfer && last_pix;
      overflow <= overflow | (valid_in && !wr);
      // geometry tracks the inputs between frames and is frozen once a frame starts
      if (state == IDLE) begin
        w <= image_width == '0 ? 13'd1 : image_width;
        h <= image_height == '0 ? 13'd1 : image_height;
      end
      if (xfer) begin
        x <= last_x ? '0 : x + 13'd1;
        y <= last_x ? (last_pix ? '0 : y + 13'd1) : y;
      end
    end
  end
endmodule

// File: tb/tb_pixel_stream_packer.sv
// tb_pixel_stream_packer: table-driven and directed checks of the pixel stream packer
module tb_pixel_stream_packer;
  logic clk = 0, reset = 1, valid_in = 0, out_tready = 0;
  logic [7:0] red = 0, green, blue;
  logic [12:0] image_width = 13'd4, image_height = 13'd2;
  logic [23:0] out_tdata;
  logic out_tvalid, out_tuser, out_tlast, frame_done, overflow;
  logic [4:0] fifo_level;
  int checks = 0, errors = 0;

  assign green = red ^ 8'h5A;
  assign blue = red + 8'h33;

  pixel_stream_packer #(.FIFO_DEPTH(16), .COLOR_W(8)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .red(red), .green(green), .blue(blue),
    .image_width(image_width), .image_height(image_height), .out_tdata(out_tdata),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tuser(out_tuser),
    .out_tlast(out_tlast), .frame_done(frame_done), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [7:0] r; logic rdy;
    logic ev; logic [7:0] er; logic eu; logic el; logic ed; logic [4:0] elev;
  } vec_t;
  vec_t tbl [11];

  function automatic logic [23:0] pix(input logic [7:0] r);
    return {r, r ^ 8'h5A, r + 8'h33};
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      valid_in = 1;
      red = 8'(base + i);
      step;
    end
    valid_in = 0;
  endtask

  task automatic expect_pixels(input int n, input int k0, input int base, input int w, input int h, input bit tog);
    int k = k0;
    int cyc = 0;
    bit pend = 0;
    bit rdy = 1;
    while (k < k0 + n && cyc < 400) begin
      out_tready = tog ? rdy : 1'b1;
      rdy = ~rdy;
      chk("frame_done", frame_done, pend);
      pend = 0;
      chk("tvalid", out_tvalid, 1);
      chk("tdata", out_tdata, pix(8'(base + k)));
      chk("tuser", out_tuser, k % (w * h) == 0);
      chk("tlast", out_tlast, k % w == w - 1);
      if (out_tready && out_tvalid) begin
        pend = k % (w * h) == w * h - 1;
        k++;
      end
      cyc++;
      step;
    end
    out_tready = 0;
    if (k < k0 + n) chk("drain_timeout", k, k0 + n);
    chk("frame_done_end", frame_done, pend);
  endtask

  task automatic reset_outputs_zero;
    chk("rst_tvalid", out_tvalid, 0);
    chk("rst_tdata", out_tdata, 0);
    chk("rst_tuser", out_tuser, 0);
    chk("rst_tlast", out_tlast, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_level", fifo_level, 0);
  endtask

  task automatic do_reset;
    reset = 1;
    #2;
    reset_outputs_zero;
    step;
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 11; i++) begin
      tbl[i].v = i < 8;
      tbl[i].r = 8'(i);
      tbl[i].rdy = 1;
      tbl[i].ev = i >= 1 && i <= 8;
      tbl[i].er = 8'(i - 1);
      tbl[i].eu = i == 1;
      tbl[i].el = i == 4 || i == 8;
      tbl[i].ed = i == 9;
      tbl[i].elev = (i >= 1 && i <= 8) ? 5'd1 : 5'd0;
    end
    repeat (2) step;
    reset_outputs_zero;
    reset = 0;
    step;
    for (int i = 0; i < 11; i++) begin
      valid_in = tbl[i].v;
      red = tbl[i].r;
      out_tready = tbl[i].rdy;
      chk("t1_tvalid", out_tvalid, tbl[i].ev);
      chk("t1_level", fifo_level, tbl[i].elev);
      chk("t1_done", frame_done, tbl[i].ed);
      chk("t1_overflow", overflow, 0);
      if (tbl[i].ev) begin
        chk("t1_tdata", out_tdata, pix(tbl[i].er));
        chk("t1_tuser", out_tuser, tbl[i].eu);
        chk("t1_tlast", out_tlast, tbl[i].el);
      end
      step;
    end
    valid_in = 0;
    out_tready = 0;
    image_width = 16;
    image_height = 1;
    step;
    push(16, 0);
    chk("t2_level_full", fifo_level, 16);
    chk("t2_ovf_before", overflow, 0);
    push(1, 16);
    chk("t2_level_drop", fifo_level, 16);
    chk("t2_ovf_set", overflow, 1);
    expect_pixels(16, 0, 0, 16, 1, 0);
    chk("t2_empty", out_tvalid, 0);
    chk("t2_level0", fifo_level, 0);
    chk("t2_ovf_sticky", overflow, 1);
    do_reset;
    push(16, 0);
    valid_in = 1;
    red = 16;
    out_tready = 1;
    chk("t3_head_user", out_tuser, 1);
    step;
    valid_in = 0;
    out_tready = 0;
    chk("t3_level", fifo_level, 16);
    chk("t3_ovf", overflow, 0);
    chk("t3_head", out_tdata, pix(8'd1));
    expect_pixels(16, 1, 0, 16, 1, 0);
    do_reset;
    image_width = 3;
    image_height = 3;
    step;
    push(9, 40);
    expect_pixels(9, 0, 40, 3, 3, 1);
    image_width = 4;
    image_height = 2;
    step;
    push(5, 60);
    expect_pixels(3, 0, 60, 4, 2, 0);
    do_reset;
    push(8, 100);
    expect_pixels(8, 0, 100, 4, 2, 0);
    image_width = 0;
    image_height = 0;
    step;
    push(3, 120);
    expect_pixels(3, 0, 120, 1, 1, 0);
    image_width = 4;
    image_height = 2;
    step;
    push(8, 130);
    expect_pixels(2, 0, 130, 4, 2, 0);
    image_width = 2;
    expect_pixels(6, 2, 130, 4, 2, 0);
    chk("end_ovf", overflow, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
